// File: rtl/pic_pkg.sv
// Shared definitions for the PIC in-service controller: OCW2 command
// encodings, the INTA sequencer states and rotate/encode helpers.
package pic_pkg;

  // Widest vector the helpers handle; callers zero-extend narrower vectors.
  localparam int MAX_LEVELS = 32;

  // OCW2 {R,SL,EOI} encodings.
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_ACK1 = 2'd1,
    ACK_ACK2 = 2'd2
  } ack_state_t;

  // Rotate the low n bits of v right by amt: bit (amt mod n) lands at bit 0.
  function automatic logic [MAX_LEVELS-1:0] rotate_right(
    input logic [MAX_LEVELS-1:0] v, input int amt, input int n);
    logic [MAX_LEVELS-1:0] r;
    logic [4:0]            src;
    r = '0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < n) begin
        src  = 5'((i + (amt % n)) % n);
        r[i] = v[src];
      end
    end
    return r;
  endfunction

  // Inverse of rotate_right for the same amt and n.
  function automatic logic [MAX_LEVELS-1:0] rotate_left(
    input logic [MAX_LEVELS-1:0] v, input int amt, input int n);
    logic [MAX_LEVELS-1:0] r;
    logic [4:0]            src;
    r = '0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < n) begin
        src  = 5'((i + n - (amt % n)) % n);
        r[i] = v[src];
      end
    end
    return r;
  endfunction

  // Encode a one-hot (or zero) vector; zero encodes as 0.
  function automatic logic [4:0] onehot_to_index(input logic [MAX_LEVELS-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (v[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_priority_resolver_n.sv
// Rotating-priority picker: level (priority_rotate+1) mod NUM_LEVELS wins,
// priority_rotate itself is lowest. Shared with the interrupt-request path.
module pic_priority_resolver_n
  import pic_pkg::*;
#(
  parameter  int NUM_LEVELS = 8,
  localparam int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic [NUM_LEVELS-1:0] request,
  input  logic [LEVEL_W-1:0]    priority_rotate,
  output logic [NUM_LEVELS-1:0] grant
);

  int                    amt;
  logic [NUM_LEVELS-1:0] rotated;
  logic [NUM_LEVELS-1:0] pick;

  // Rotate the highest-priority level down to bit 0, keep the lowest set
  // bit, then rotate the single survivor back into place.
  always_comb begin
    amt     = (int'(priority_rotate) + 1) % NUM_LEVELS;
    rotated = NUM_LEVELS'(rotate_right(32'(request), amt, NUM_LEVELS));
    pick    = rotated & (~rotated + NUM_LEVELS'(1));
    grant   = NUM_LEVELS'(rotate_left(32'(pick), amt, NUM_LEVELS));
  end

endmodule

// File: rtl/in_service_ctrl_pic.sv
// In-service register controller: ISR, rotating priority, INTA sequencer,
// OCW2 EOI/rotate commands and automatic EOI. State moves on falling clock.
module in_service_ctrl_pic
  import pic_pkg::*;
#(
  parameter  int NUM_LEVELS = 8,
  localparam int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] interrupt,
  input  logic                  ack_pulse,
  input  logic                  mode_8086,
  input  logic                  auto_eoi,
  input  logic                  special_mask_mode,
  input  logic [NUM_LEVELS-1:0] interrupt_mask,
  input  logic                  eoi_cmd_valid,
  input  logic [2:0]            eoi_cmd_type,
  input  logic [LEVEL_W-1:0]    eoi_cmd_level,
  output logic [NUM_LEVELS-1:0] in_service_register,
  output logic [NUM_LEVELS-1:0] highest_level_in_service,
  output logic [LEVEL_W-1:0]    highest_level_index,
  output logic                  in_service_any,
  output logic [LEVEL_W-1:0]    priority_rotate,
  output logic                  rotate_in_aeoi,
  output logic                  ack_busy,
  output logic                  ack_last
);

  localparam logic [NUM_LEVELS-1:0] ONE = NUM_LEVELS'(1);

  ack_state_t            state, state_nx;
  logic [LEVEL_W-1:0]    ack_level, ack_level_nx;
  logic                  ack_hit, ack_hit_nx;   // first pulse latched a real level
  logic                  ack_mode, ack_mode_nx; // mode_8086 frozen for the sequence
  logic                  last_nx;

  logic [NUM_LEVELS-1:0] isr_q, isr_nx, set_vec, clr_vec, eff_req;
  logic [NUM_LEVELS-1:0] hi_q, hi_nx;
  logic [LEVEL_W-1:0]    hidx_q, hidx_nx;
  logic                  any_q;
  logic [LEVEL_W-1:0]    rot_q, rot_nx;
  logic                  raeoi_q, raeoi_nx;
  logic                  last_q;
  logic                  lvl_ok;

  // Level operands past the top level void the command; only reachable
  // when NUM_LEVELS is not a power of two.
  if (2**LEVEL_W > NUM_LEVELS) begin : g_lvl_chk
    assign lvl_ok = (eoi_cmd_level < LEVEL_W'(NUM_LEVELS));
  end else begin : g_lvl_all
    assign lvl_ok = 1'b1;
  end

  // INTA sequencer: first pulse latches the grant, last pulse ends it.
  always_comb begin
    state_nx     = state;
    ack_level_nx = ack_level;
    ack_hit_nx   = ack_hit;
    ack_mode_nx  = ack_mode;
    set_vec      = '0;
    last_nx      = 1'b0;
    case (state)
      ACK_IDLE: if (ack_pulse) begin
        set_vec      = interrupt;
        ack_level_nx = LEVEL_W'(onehot_to_index(32'(interrupt)));
        ack_hit_nx   = |interrupt;
        ack_mode_nx  = mode_8086;
        state_nx     = ACK_ACK1;
      end
      ACK_ACK1: if (ack_pulse) begin
        if (ack_mode) begin
          last_nx  = 1'b1;
          state_nx = ACK_IDLE;
        end else begin
          state_nx = ACK_ACK2;
        end
      end
      ACK_ACK2: if (ack_pulse) begin
        last_nx  = 1'b1;
        state_nx = ACK_IDLE;
      end
      default: state_nx = ACK_IDLE;
    endcase
  end

  // Clear vector and rotation: AEOI first, explicit command overrides rotation.
  always_comb begin
    clr_vec  = '0;
    rot_nx   = rot_q;
    raeoi_nx = raeoi_q;
    if (last_nx && auto_eoi && ack_hit) begin
      clr_vec = clr_vec | (ONE << ack_level);
      if (raeoi_q) rot_nx = ack_level;
    end
    if (eoi_cmd_valid) begin
      case (eoi_cmd_type)
        OCW2_NS_EOI: if (any_q) clr_vec = clr_vec | hi_q;
        OCW2_SP_EOI: if (lvl_ok) clr_vec = clr_vec | (ONE << eoi_cmd_level);
        OCW2_ROT_NS_EOI: if (any_q) begin
          clr_vec = clr_vec | hi_q;
          rot_nx  = hidx_q;
        end
        OCW2_ROT_SP_EOI: if (lvl_ok) begin
          clr_vec = clr_vec | (ONE << eoi_cmd_level);
          rot_nx  = eoi_cmd_level;
        end
        OCW2_SET_PRI:      if (lvl_ok) rot_nx = eoi_cmd_level;
        OCW2_ROT_AEOI_SET: raeoi_nx = 1'b1;
        OCW2_ROT_AEOI_CLR: raeoi_nx = 1'b0;
        default: ;
      endcase
    end
  end

  // Next ISR (set beats clear) and the in-service priority view of it.
  always_comb begin
    isr_nx  = (isr_q & ~clr_vec) | set_vec;
    eff_req = isr_nx & ~(special_mask_mode ? interrupt_mask : '0);
    hidx_nx = LEVEL_W'(onehot_to_index(32'(hi_nx)));
  end

  pic_priority_resolver_n #(.NUM_LEVELS(NUM_LEVELS)) u_isr_prio (
    .request         (eff_req),
    .priority_rotate (rot_nx),
    .grant           (hi_nx)
  );

  // All state on the falling edge; highest-level view registered with the ISR.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state     <= ACK_IDLE;
      ack_level <= '0;
      ack_hit   <= 1'b0;
      ack_mode  <= 1'b0;
      isr_q     <= '0;
      hi_q      <= '0;
      hidx_q    <= '0;
      any_q     <= 1'b0;
      rot_q     <= LEVEL_W'(NUM_LEVELS - 1);
      raeoi_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      ack_level <= ack_level_nx;
      ack_hit   <= ack_hit_nx;
      ack_mode  <= ack_mode_nx;
      isr_q     <= isr_nx;
      hi_q      <= hi_nx;
      hidx_q    <= hidx_nx;
      any_q     <= |hi_nx;
      rot_q     <= rot_nx;
      raeoi_q   <= raeoi_nx;
      last_q    <= last_nx;
    end
  end

  assign in_service_register      = isr_q;
  assign highest_level_in_service = hi_q;
  assign highest_level_index      = hidx_q;
  assign in_service_any           = any_q;
  assign priority_rotate          = rot_q;
  assign rotate_in_aeoi           = raeoi_q;
  assign ack_busy                 = (state != ACK_IDLE);
  assign ack_last                 = last_q;

endmodule

// File: tb/tb_in_service_ctrl_pic.sv
// Bench for in_service_ctrl_pic: an 8-level and a 5-level instance, each
// tracked by a behavioural model written from the level/priority rules.
module tb_in_service_ctrl_pic;

  typedef struct {
    logic [31:0] intr;
    logic [31:0] mask;
    logic [31:0] cl;
    logic [2:0]  ct;
    logic        ack, m86, aeoi, smm, cv;
  } in_t;

  typedef struct {
    logic [31:0] isr;
    logic [31:0] hi;
    int          rot;
    int          ph;    // 0 idle, 1 after first pulse, 2 after second
    int          lvl;   // latched level, -1 when the ack was spurious
    logic        amode;
    logic        raeoi;
    logic        last;
  } mdl_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  in_t  ia, ib;
  mdl_t ma, mb;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] a_isr, a_hi;
  logic [2:0] a_idx, a_rot;
  logic       a_any, a_raeoi, a_busy, a_last;
  logic [4:0] b_isr, b_hi;
  logic [2:0] b_idx, b_rot;
  logic       b_any, b_raeoi, b_busy, b_last;

  in_service_ctrl_pic #(.NUM_LEVELS(8)) dut_a (
    .clock(clock), .reset(reset), .interrupt(ia.intr[7:0]), .ack_pulse(ia.ack),
    .mode_8086(ia.m86), .auto_eoi(ia.aeoi), .special_mask_mode(ia.smm),
    .interrupt_mask(ia.mask[7:0]), .eoi_cmd_valid(ia.cv), .eoi_cmd_type(ia.ct),
    .eoi_cmd_level(ia.cl[2:0]), .in_service_register(a_isr),
    .highest_level_in_service(a_hi), .highest_level_index(a_idx),
    .in_service_any(a_any), .priority_rotate(a_rot), .rotate_in_aeoi(a_raeoi),
    .ack_busy(a_busy), .ack_last(a_last));

  in_service_ctrl_pic #(.NUM_LEVELS(5)) dut_b (
    .clock(clock), .reset(reset), .interrupt(ib.intr[4:0]), .ack_pulse(ib.ack),
    .mode_8086(ib.m86), .auto_eoi(ib.aeoi), .special_mask_mode(ib.smm),
    .interrupt_mask(ib.mask[4:0]), .eoi_cmd_valid(ib.cv), .eoi_cmd_type(ib.ct),
    .eoi_cmd_level(ib.cl[2:0]), .in_service_register(b_isr),
    .highest_level_in_service(b_hi), .highest_level_index(b_idx),
    .in_service_any(b_any), .priority_rotate(b_rot), .rotate_in_aeoi(b_raeoi),
    .ack_busy(b_busy), .ack_last(b_last));

  function automatic mdl_t mrst(int n);
    mdl_t r;
    r.isr = 0; r.hi = 0; r.rot = n - 1; r.ph = 0; r.lvl = -1;
    r.amode = 0; r.raeoi = 0; r.last = 0;
    return r;
  endfunction

  function automatic int oh_idx(logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Walk levels from rot+1 upward (wrapping); first set bit wins.
  function automatic int mhigh(logic [31:0] v, int n, int rot);
    int l;
    for (int k = 1; k <= n; k++) begin
      l = (rot + k) % n;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int n, in_t x);
    mdl_t        r;
    logic [31:0] setv, clrv, eff, lim;
    int          h;
    r = m; setv = 0; clrv = 0; r.last = 0;
    lim = (32'(1) << n) - 1;
    if (x.ack) begin
      if (m.ph == 0) begin
        setv = x.intr & lim; r.ph = 1; r.amode = x.m86;
        r.lvl = ((x.intr & lim) != 0) ? oh_idx(x.intr) : -1;
      end else if (m.ph == 2 || m.amode) begin
        r.last = 1; r.ph = 0;
      end else begin
        r.ph = 2;
      end
    end
    if (r.last && x.aeoi && m.lvl >= 0) begin
      clrv = clrv | (32'(1) << m.lvl);
      if (m.raeoi) r.rot = m.lvl;
    end
    if (x.cv) begin
      case (x.ct)
        3'b001: if (m.hi != 0) clrv = clrv | m.hi;
        3'b011: if (x.cl < n) clrv = clrv | (32'(1) << x.cl);
        3'b101: if (m.hi != 0) begin clrv = clrv | m.hi; r.rot = oh_idx(m.hi); end
        3'b111: if (x.cl < n) begin clrv = clrv | (32'(1) << x.cl); r.rot = int'(x.cl); end
        3'b110: if (x.cl < n) r.rot = int'(x.cl);
        3'b100: r.raeoi = 1;
        3'b000: r.raeoi = 0;
        default: ;
      endcase
    end
    r.isr = (m.isr & ~clrv) | setv;
    eff   = r.isr & ~(x.smm ? x.mask : 32'd0);
    h     = mhigh(eff, n, r.rot);
    r.hi  = (h < 0) ? 32'd0 : (32'(1) << h);
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(string t);
    chk({t, " A.isr"},   32'(a_isr),   ma.isr);
    chk({t, " A.hi"},    32'(a_hi),    ma.hi);
    chk({t, " A.idx"},   32'(a_idx),   32'(oh_idx(ma.hi)));
    chk({t, " A.any"},   32'(a_any),   32'(ma.hi != 0));
    chk({t, " A.rot"},   32'(a_rot),   32'(ma.rot));
    chk({t, " A.raeoi"}, 32'(a_raeoi), 32'(ma.raeoi));
    chk({t, " A.busy"},  32'(a_busy),  32'(ma.ph != 0));
    chk({t, " A.last"},  32'(a_last),  32'(ma.last));
  endtask

  task automatic chk_b(string t);
    chk({t, " B.isr"},   32'(b_isr),   mb.isr);
    chk({t, " B.hi"},    32'(b_hi),    mb.hi);
    chk({t, " B.idx"},   32'(b_idx),   32'(oh_idx(mb.hi)));
    chk({t, " B.any"},   32'(b_any),   32'(mb.hi != 0));
    chk({t, " B.rot"},   32'(b_rot),   32'(mb.rot));
    chk({t, " B.raeoi"}, 32'(b_raeoi), 32'(mb.raeoi));
    chk({t, " B.busy"},  32'(b_busy),  32'(mb.ph != 0));
    chk({t, " B.last"},  32'(b_last),  32'(mb.last));
  endtask

  // One falling edge: DUT and models consume the same inputs, strobes drop.
  task automatic tick();
    @(negedge clock);
    ma = mstep(ma, 8, ia);
    mb = mstep(mb, 5, ib);
    #1;
    ia.ack = 0; ia.cv = 0; ib.ack = 0; ib.cv = 0;
  endtask

  task automatic pulse_a(); ia.ack = 1; tick(); endtask
  task automatic pulse_b(); ib.ack = 1; tick(); endtask
  task automatic cmd_a(logic [2:0] t, int l); ia.cv = 1; ia.ct = t; ia.cl = 32'(l); tick(); endtask
  task automatic cmd_b(logic [2:0] t, int l); ib.cv = 1; ib.ct = t; ib.cl = 32'(l); tick(); endtask

  initial begin
    ia = '{default: '0};
    ib = '{default: '0};
    ma = mrst(8);
    mb = mrst(5);
    #12;
    chk_a("reset"); chk_b("reset");
    chk("reset rotA", 32'(a_rot), 32'd7);
    chk("reset rotB", 32'(b_rot), 32'd4);
    reset = 0;

    // Two-pulse 8086 sequence on level 3.
    ia.m86 = 1; ia.intr = 32'h08;
    pulse_a(); chk_a("t1 p1"); chk("t1 isr", 32'(a_isr), 32'h08);
    pulse_a(); chk_a("t1 p2"); chk("t1 last", 32'(a_last), 1); chk("t1 idx", 32'(a_idx), 3);
    tick(); chk_a("t1 idle");

    // ISR=0x28, non-specific EOI clears level 3.
    ia.intr = 32'h20; pulse_a(); pulse_a(); chk("t2 isr28", 32'(a_isr), 32'h28);
    cmd_a(3'b001, 0); chk_a("t2 eoi");
    chk("t2 isr", 32'(a_isr), 32'h20); chk("t2 hi", 32'(a_hi), 32'h20);

    // Rotate on non-specific EOI, then level 5 outranks level 0.
    ia.intr = 32'h08; pulse_a(); pulse_a();
    cmd_a(3'b101, 0); chk_a("t3 rot");
    chk("t3 isr", 32'(a_isr), 32'h20); chk("t3 rot", 32'(a_rot), 3);
    ia.intr = 32'h01; pulse_a(); chk_a("t3 latch"); chk("t3 hi", 32'(a_hi), 32'h20);
    pulse_a();
    cmd_a(3'b011, 0); cmd_a(3'b011, 5); chk_a("t3 clean");

    // AEOI with rotate-on-AEOI over a three-pulse 8080 sequence.
    ia.aeoi = 1; cmd_a(3'b100, 0); chk_a("t4 raeoi");
    ia.m86 = 0; ia.intr = 32'h40;
    pulse_a(); chk_a("t4 p1"); chk("t4 p1 isr", 32'(a_isr), 32'h40);
    pulse_a(); chk_a("t4 p2"); chk("t4 p2 isr", 32'(a_isr), 32'h40);
    pulse_a(); chk_a("t4 p3"); chk("t4 p3 isr", 32'(a_isr), 0);
    chk("t4 p3 rot", 32'(a_rot), 6);

    // Spurious ack with AEOI: sequence completes, nothing cleared/rotated.
    ia.intr = 0; pulse_a(); pulse_a(); pulse_a(); chk_a("spur");
    chk("spur rot", 32'(a_rot), 6);

    // AEOI and explicit set-priority together: command rotation wins.
    ia.m86 = 1; ia.intr = 32'h02; pulse_a();
    ia.ack = 1; cmd_a(3'b110, 2); chk_a("sim rot"); chk("sim rot", 32'(a_rot), 2);

    // First-pulse latch and a specific EOI on the same bit: set wins.
    ia.aeoi = 0; ia.intr = 32'h08;
    ia.ack = 1; cmd_a(3'b011, 3); chk_a("sim set"); chk("sim set isr", 32'(a_isr), 32'h08);
    pulse_a(); cmd_a(3'b011, 3); chk_a("sim clean");

    // mode_8086 flips mid-sequence; the latched 8080 mode still applies.
    ia.m86 = 0; ia.intr = 32'h10; pulse_a();
    ia.m86 = 1; pulse_a(); chk_a("mode p2"); chk("mode busy", 32'(a_busy), 1);
    pulse_a(); chk_a("mode p3");
    cmd_a(3'b011, 4);

    // Special mask mode hides level 1 from the in-service priority.
    ia.smm = 1; ia.mask = 32'h02;
    ia.intr = 32'h02; pulse_a(); pulse_a();
    ia.intr = 32'h04; pulse_a(); pulse_a(); chk_a("smm");
    chk("smm hi", 32'(a_hi), 32'h04);
    cmd_a(3'b011, 1); chk_a("smm eoi"); chk("smm isr", 32'(a_isr), 32'h04);

    // Five levels: wrap priority, illegal level operands ignored.
    cmd_b(3'b110, 4);
    ib.m86 = 1; ib.intr = 32'h10; pulse_b(); pulse_b();
    ib.intr = 32'h01; pulse_b(); pulse_b(); chk_b("wrap");
    chk("wrap hi", 32'(b_hi), 32'h01);
    cmd_b(3'b011, 6); chk_b("bad sp");
    cmd_b(3'b111, 7); chk_b("bad rsp");
    cmd_b(3'b110, 5); chk_b("bad pri"); chk("bad pri rot", 32'(b_rot), 4);

    // Asynchronous reset during ACK1, then a fresh first pulse.
    cmd_b(3'b011, 0); cmd_b(3'b011, 4);
    ib.intr = 32'h04; pulse_b(); chk_b("mid p1");
    reset = 1; #2;
    ma = mrst(8); mb = mrst(5);
    chk_a("mid rst"); chk_b("mid rst"); chk("mid rst isr", 32'(b_isr), 0);
    reset = 0;
    pulse_b(); chk_b("mid relatch"); chk("mid relatch isr", 32'(b_isr), 32'h04);
    chk("mid relatch busy", 32'(b_busy), 1);

    // Randomised traffic on both instances.
    ia.smm = 0; ia.mask = 0;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 8);
      ia.intr = (r == 8) ? 32'd0 : (32'(1) << r);
      r = $urandom_range(0, 5);
      ib.intr = (r == 5) ? 32'd0 : (32'(1) << r);
      ia.ack = ($urandom_range(0, 2) == 0); ib.ack = ($urandom_range(0, 2) == 0);
      ia.m86 = 1'($urandom); ib.m86 = 1'($urandom);
      ia.aeoi = 1'($urandom); ib.aeoi = 1'($urandom);
      ia.smm = ($urandom_range(0, 3) == 0); ib.smm = ($urandom_range(0, 3) == 0);
      ia.mask = 32'($urandom_range(0, 255)); ib.mask = 32'($urandom_range(0, 31));
      ia.cv = ($urandom_range(0, 3) == 0); ib.cv = ($urandom_range(0, 3) == 0);
      ia.ct = 3'($urandom); ib.ct = 3'($urandom);
      ia.cl = 32'($urandom_range(0, 7)); ib.cl = 32'($urandom_range(0, 7));
      tick();
      chk_a("rnd"); chk_b("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
